// File: rtl/qpi_rom_bridge.sv
// ============================================================================
// Module      : qpi_rom_bridge
// Description : Read-request front end for the QPI flash controller. Serves
//               single-byte ROM reads from a small byte buffer (entry D = last
//               demand fetch, entry P = sequential prefetch) and otherwise
//               issues one-byte reads through the qpi_flash read/addr/ready/
//               data_out handshake.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               cpu_req/cpu_addr   - one-cycle request strobe and byte address
//               cpu_data/cpu_ack   - read data and one-cycle completion strobe
//               busy               - high from accepted request until its ack
//               flash_ready/flash_data        - from qpi_flash
//               flash_read/flash_addr         - to qpi_flash
// Config      : define QPI_ROM_BRIDGE_PREFETCH_EN to build entry P, the
//               PF_CHECK state and the one-deep pending request register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpi_rom_bridge #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ack,
  output logic              busy,
  input  logic              flash_ready,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [7:0]        flash_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DROP = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
  localparam logic [2:0]        S_PF_CHECK = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              d_vld_q, d_vld_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [7:0]        d_data_q, d_data_d;
  logic [7:0]        data_q, data_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              w_accept;
  logic              w_req_vld;
  logic [ADDR_W-1:0] w_req_addr;

`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
  logic              p_vld_q, p_vld_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [7:0]        p_data_q, p_data_d;
  logic              pf_q, pf_d;         // current flash transaction is a prefetch
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] w_next;

  // Natural ADDR_W-bit wrap takes the last byte back to address zero.
  assign w_next = d_addr_q + ADDR_ONE;
`endif

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    d_vld_d  = d_vld_q;
    d_addr_d = d_addr_q;
    d_data_d = d_data_q;
    data_d   = data_q;
    ack_d    = 1'b0;
    // busy is only low when no demand or parked request is outstanding, so a
    // request seen while busy is a protocol violation and simply dropped.
    w_accept = cpu_req & ~busy_q;
    busy_d   = w_accept | (busy_q & ~ack_q);
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
    p_vld_d     = p_vld_q;
    p_addr_d    = p_addr_q;
    p_data_d    = p_data_q;
    pf_d        = pf_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    // Outside IDLE, busy can only be low while a prefetch is in flight; park
    // the request until that flash transaction finishes.
    if (w_accept && (state_q != S_IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = cpu_addr;
    end
    w_req_vld  = (state_q == S_IDLE) && (pend_vld_q || w_accept);
    w_req_addr = pend_vld_q ? pend_addr_q : cpu_addr;
`else
    w_req_vld  = (state_q == S_IDLE) && w_accept;
    w_req_addr = cpu_addr;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_req_vld) begin
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
          pend_vld_d = 1'b0;
          // P wins over D; promote it to D so streaming keeps going.
          if (p_vld_q && (p_addr_q == w_req_addr)) begin
            ack_d    = 1'b1;
            data_d   = p_data_q;
            d_vld_d  = 1'b1;
            d_addr_d = p_addr_q;
            d_data_d = p_data_q;
            state_d  = S_PF_CHECK;
          end else
`endif
          if (d_vld_q && (d_addr_q == w_req_addr)) begin
            ack_d  = 1'b1;
            data_d = d_data_q;
          end else begin
            tgt_d   = w_req_addr;
            state_d = S_ISSUE;
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
            pf_d    = 1'b0;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (flash_ready) begin
          state_d = S_WAIT_DROP;
        end
      end
      // qpi_flash lowers ready one cycle after the read strobe, so ready is
      // not trusted in this cycle.
      S_WAIT_DROP: state_d = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (flash_ready) begin
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
          if (pf_q) begin
            p_vld_d  = 1'b1;
            p_addr_d = tgt_q;
            p_data_d = flash_data;
            state_d  = S_IDLE;
            // Parked request for exactly this byte: answer it right away.
            if (pend_vld_d && (pend_addr_d == tgt_q)) begin
              pend_vld_d = 1'b0;
              ack_d      = 1'b1;
              data_d     = flash_data;
              d_vld_d    = 1'b1;
              d_addr_d   = tgt_q;
              d_data_d   = flash_data;
              state_d    = S_PF_CHECK;
            end
          end else begin
            ack_d    = 1'b1;
            data_d   = flash_data;
            d_vld_d  = 1'b1;
            d_addr_d = tgt_q;
            d_data_d = flash_data;
            state_d  = S_PF_CHECK;
          end
`else
          ack_d    = 1'b1;
          data_d   = flash_data;
          d_vld_d  = 1'b1;
          d_addr_d = tgt_q;
          d_data_d = flash_data;
          state_d  = S_IDLE;
`endif
        end
      end
`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
      S_PF_CHECK: begin
        state_d = S_IDLE;
        if (!(p_vld_q && (p_addr_q == w_next))) begin
          tgt_d   = w_next;
          p_vld_d = 1'b0;
          pf_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      d_vld_q  <= 1'b0;
      d_addr_q <= '0;
      d_data_q <= 8'h00;
      data_q   <= 8'h00;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      d_vld_q  <= d_vld_d;
      d_addr_q <= d_addr_d;
      d_data_q <= d_data_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

`ifdef QPI_ROM_BRIDGE_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld_q     <= 1'b0;
      p_addr_q    <= '0;
      p_data_q    <= 8'h00;
      pf_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      p_vld_q     <= p_vld_d;
      p_addr_q    <= p_addr_d;
      p_data_q    <= p_data_d;
      pf_q        <= pf_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end
`endif

  assign cpu_data   = data_q;
  assign cpu_ack    = ack_q;
  assign busy       = busy_q;
  assign flash_read = (state_q == S_ISSUE) & flash_ready;
  assign flash_addr = tgt_q;

endmodule

`default_nettype wire
